// File: rtl/cpu_pkg.sv
// Shared CPU definitions: one-hot ALU operation bit positions and vector width.
// Used by the decode stage to build alu_op and by the execute stage to consume it.
package cpu_pkg;
  localparam int ALU_OP_W = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
endpackage

// File: rtl/alu.sv
// Combinational ALU; each one-hot op bit gates its own result and the results are OR-ed,
// so an all-zero op vector yields zero.
module alu #(
  parameter int ALU_OP_W = cpu_pkg::ALU_OP_W
) (
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  output logic [31:0]         alu_result
);
  import cpu_pkg::*;

  logic [4:0]         shamt_s;
  logic [31:0]        add_s;
  logic [31:0]        sub_s;
  logic [31:0]        slt_s;
  logic [31:0]        sltu_s;
  logic [31:0]        sll_s;
  logic [31:0]        srl_s;
  logic signed [31:0] sra_s;

  assign shamt_s = alu_src2[4:0];
  assign add_s   = alu_src1 + alu_src2;
  assign sub_s   = alu_src1 - alu_src2;
  assign slt_s   = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
  assign sltu_s  = {31'd0, (alu_src1 < alu_src2)};
  assign sll_s   = alu_src1 << shamt_s;
  assign srl_s   = alu_src1 >> shamt_s;
  assign sra_s   = $signed(alu_src1) >>> shamt_s;

  assign alu_result = ({32{alu_op[ALU_ADD]}}  & add_s)
                    | ({32{alu_op[ALU_SUB]}}  & sub_s)
                    | ({32{alu_op[ALU_SLT]}}  & slt_s)
                    | ({32{alu_op[ALU_SLTU]}} & sltu_s)
                    | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[ALU_SLL]}}  & sll_s)
                    | ({32{alu_op[ALU_SRL]}}  & srl_s)
                    | ({32{alu_op[ALU_SRA]}}  & sra_s)
                    | ({32{alu_op[ALU_LUI]}}  & alu_src2);
endmodule

// File: rtl/pipe_ctrl.sv
// Generic pipeline-stage handshake: a single valid bit with ready/valid flow control.
module pipe_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic validin,
  input  logic allowout,
  input  logic readygo,
  output logic allowin,
  output logic validout,
  output logic valid
);
  logic valid_r;

  assign allowin  = !valid_r || (readygo && allowout);
  assign validout = valid_r && readygo;
  assign valid    = valid_r;

  // Stage occupancy: take the upstream valid whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (allowin) begin
      valid_r <= validin;
    end
  end
endmodule

// File: rtl/stage_exe.sv
// Execute stage: latches decode results, computes the ALU result combinationally and
// issues at most one data-SRAM request per instruction, on the cycle it advances.
module stage_exe #(
  parameter int ALU_OP_W = cpu_pkg::ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                validin,
  input  logic                allowout,
  output logic                allowin,
  output logic                validout,
  input  logic [31:0]         input_pc,
  input  logic [31:0]         input_alu_src1,
  input  logic [31:0]         input_alu_src2,
  input  logic [ALU_OP_W-1:0] input_alu_op,
  input  logic [31:0]         input_mem_data,
  input  logic                input_mem_read,
  input  logic                input_mem_write,
  input  logic [4:0]          input_rf_waddr,
  input  logic                input_rf_we,
  output logic [31:0]         output_pc,
  output logic [31:0]         output_alu_result,
  output logic                output_mem_read,
  output logic [4:0]          output_rf_waddr,
  output logic                output_rf_we,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic [4:0]          exe_hz_waddr,
  output logic                exe_hz_we
);
  logic                valid_s;
  logic                fire_s;
  logic [31:0]         pc_r;
  logic [31:0]         src1_r;
  logic [31:0]         src2_r;
  logic [ALU_OP_W-1:0] op_r;
  logic [31:0]         mem_data_r;
  logic                mem_read_r;
  logic                mem_write_r;
  logic [4:0]          rf_waddr_r;
  logic                rf_we_r;
  logic [31:0]         alu_result_s;

  pipe_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .validin  (validin),
    .allowout (allowout),
    .readygo  (1'b1),
    .allowin  (allowin),
    .validout (validout),
    .valid    (valid_s)
  );

  // Payload capture: only on an accepted transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= 32'd0;
      src1_r      <= 32'd0;
      src2_r      <= 32'd0;
      op_r        <= '0;
      mem_data_r  <= 32'd0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_we_r     <= 1'b0;
    end else if (allowin && validin) begin
      pc_r        <= input_pc;
      src1_r      <= input_alu_src1;
      src2_r      <= input_alu_src2;
      op_r        <= input_alu_op;
      mem_data_r  <= input_mem_data;
      mem_read_r  <= input_mem_read;
      mem_write_r <= input_mem_write;
      rf_waddr_r  <= input_rf_waddr;
      rf_we_r     <= input_rf_we;
    end
  end

  alu #(.ALU_OP_W(ALU_OP_W)) u_alu (
    .alu_op     (op_r),
    .alu_src1   (src1_r),
    .alu_src2   (src2_r),
    .alu_result (alu_result_s)
  );

  // Request only on the advancing cycle; an in-flight op is dropped while rst is high.
  assign fire_s = valid_s && allowout && !rst;

  assign output_pc         = pc_r;
  assign output_alu_result = alu_result_s;
  assign output_mem_read   = mem_read_r;
  assign output_rf_waddr   = rf_waddr_r;
  assign output_rf_we      = rf_we_r;

  assign data_sram_en    = fire_s && (mem_read_r || mem_write_r);
  assign data_sram_we    = {4{fire_s && mem_write_r}};
  assign data_sram_addr  = alu_result_s;
  assign data_sram_wdata = mem_data_r;

  assign exe_hz_we    = valid_s && rf_we_r && (rf_waddr_r != 5'd0);
  assign exe_hz_waddr = rf_waddr_r;
endmodule
